dp_ram_be: RTL and testbench
============================

Name: dp_ram_be

Overview:
- Parametrised successor to the single-port word-aligned data RAM with byte enables.
- Provides one write port and one independent read port, so a load and a store can complete in the same cycle.
- Read is synchronous with a registered valid, byte addressing is converted internally to word indices, and out-of-range accesses are flagged.
- Sits behind the load/store unit of the RV32I core as the data memory.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8. BE_W = DATA_WIDTH/8.
- DEPTH, 256: number of words; any value >= 2.
- ADDR_WIDTH, 32: width of the byte address ports.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request, sampled on clk.
- rd_addr  in  ADDR_WIDTH  read byte address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data holds the result of the request from the previous cycle.
- rd_err  out  1  the previous read request was out of range.
- wr_en  in  1  write request, sampled on clk.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[i*8 +: 8].
- wr_addr  in  ADDR_WIDTH  write byte address.
- wr_data  in  DATA_WIDTH  write data.
- wr_err  out  1  the previous write request was out of range.

Behaviour:
- Word index = addr >> log2(BE_W). The low log2(BE_W) address bits are ignored, so accesses are always word-aligned.
- An access is out of range when its word index >= DEPTH.
- Storage is not reset. It initialises to all zeros at elaboration/configuration and is inferred as block RAM.
- Reset (rst_n low, asynchronous): rd_data=0, rd_valid=0, rd_err=0, wr_err=0.
  - While rst_n is low, writes are suppressed and memory contents are preserved.
  - A read in flight when reset asserts is discarded: rd_valid stays 0 after reset releases until a new request arrives.
- Write:
  - On a rising edge with wr_en=1 and an in-range address, each byte i with wr_be[i]=1 is updated. Other bytes are unchanged.
  - wr_be=0 is a legal no-op and raises no error.
  - An out-of-range write modifies nothing. wr_err=1 for exactly the following cycle.
  - wr_err is 0 in any cycle after an edge that had no out-of-range write.
- Read, latency 1:
  - A request with rd_en=1 at edge N gives rd_valid=1 after edge N.
  - rd_data = mem[index] for an in-range request, with rd_err=0.
  - rd_data = 0 for an out-of-range request, with rd_err=1.
  - If rd_en=0 at edge N: rd_valid=0 and rd_err=0 after it, and rd_data holds its previous value.
  - Back-to-back reads sustain one result per cycle.
- Read/write to different words in the same cycle: the two operations are independent.
- Read/write to the same word in the same cycle: behaviour depends on RAM_BYPASS_EN (see Optional Feature).
- Write-then-read on consecutive cycles to the same word always returns the new data.
- Elaboration check: DATA_WIDTH%8 != 0 or DEPTH < 2 is a fatal error.

Optional Feature:
- Macro: RAM_BYPASS_EN.
- Defined: a same-word collision forwards write data byte-wise.
  - Byte i of rd_data = wr_data byte i when wr_be[i]=1, else the stored byte.
  - The read therefore returns the post-write word.
- Undefined: a same-word collision is read-first; rd_data returns the word as it was before the write.
- Both modes: the memory update itself, rd_valid and the error flags are identical.

Test Plan (DATA_WIDTH=32, DEPTH=256):
- Reset, then read addr 0x10 -> one cycle later rd_valid=1, rd_data=0x00000000, rd_err=0.
- Write 0xDEADBEEF with be=4'hF to 0x20, then write 0x000000AA with be=4'h1 to 0x20, then read 0x23 -> rd_data=0xDEADBEAA, rd_valid=1.
- Same cycle: word 0x40 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 to 0x40 and read 0x40.
  - With RAM_BYPASS_EN: rd_data=0x11BB33DD.
  - Without it: rd_data=0x11223344.
  - A read of 0x40 on the next cycle returns 0x11BB33DD in both modes.
- Write to 0x400 (index 256) -> wr_err=1 for one cycle and no word changes. Read 0x400 -> rd_data=0, rd_err=1.
- Reads every cycle to 0x0, 0x4, 0x8 after writing 1, 2, 3 to those words -> rd_data sequence 1, 2, 3 on consecutive cycles with rd_valid held at 1.
- Assert rst_n low mid-read while also driving a write of 0x55 to 0x8 -> outputs go to 0 immediately and word 0x8 still reads 3 after reset releases.

Source files
------------

// File: rtl/dp_ram_be.sv
// Dual-port data RAM: one byte-enabled write port, one synchronous read port.
// Optional macro RAM_BYPASS_EN forwards same-word write bytes to the read port.
module dp_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_err,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_err
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CMP_W = ADDR_WIDTH + 32;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $fatal(1, "dp_ram_be: DATA_WIDTH must be a multiple of 8");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $fatal(1, "dp_ram_be: DEPTH must be at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-1:0] rd_word, wr_word;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  rd_in_range, wr_in_range;

    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  rd_valid_d, rd_valid_q;
    logic                  rd_err_d, rd_err_q;
    logic                  wr_err_d, wr_err_q;

    assign rd_word = rd_addr >> OFF_W;
    assign wr_word = wr_addr >> OFF_W;
    // Compare at a widened width so DEPTH is never truncated by a narrow address.
    assign rd_in_range = CMP_W'(rd_word) < CMP_W'(DEPTH);
    assign wr_in_range = CMP_W'(wr_word) < CMP_W'(DEPTH);
    assign rd_idx = rd_word[IDX_W-1:0];
    assign wr_idx = wr_word[IDX_W-1:0];

    // Storage has no reset; the async term only blocks writes while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && wr_en && wr_in_range) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && !rd_in_range;
        wr_err_d   = wr_en && !wr_in_range;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            if (rd_in_range) begin
                rd_data_d = mem[rd_idx];
`ifdef RAM_BYPASS_EN
                if (wr_en && wr_in_range && (rd_idx == wr_idx)) begin
                    for (int unsigned i = 0; i < BE_W; i++) begin
                        if (wr_be[i]) begin
                            rd_data_d[i*8 +: 8] = wr_data[i*8 +: 8];
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// Self-checking bench for dp_ram_be: directed vector table, reset corner case,
// and randomized traffic checked against a word-array reference model.
module tb_dp_ram_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    dp_ram_be #(
        .DATA_WIDTH(32),
        .DEPTH     (256),
        .ADDR_WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_err  (rd_err),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    // Reference model: array of words plus expected output registers
    logic [31:0] m_mem [256];
    logic [31:0] m_data;
    logic        m_valid, m_err, m_werr;

    typedef struct {
        logic        rd_en;
        logic [31:0] rd_addr;
        logic        wr_en;
        logic [3:0]  wr_be;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_werr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic re, logic [31:0] ra, logic we, logic [3:0] be,
                                logic [31:0] wa, logic [31:0] wd, logic ev,
                                logic [31:0] ed, logic ee, logic ew);
        vec_t v;
        v.rd_en = re; v.rd_addr = ra; v.wr_en = we; v.wr_be = be;
        v.wr_addr = wa; v.wr_data = wd; v.e_valid = ev; v.e_data = ed;
        v.e_err = ee; v.e_werr = ew;
        vecs.push_back(v);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w,
                                          logic [3:0] be);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Predict from current inputs, advance one clock, compare against the model.
    task automatic tick(input string name);
        int unsigned ri = rd_addr / 4;
        int unsigned wi = wr_addr / 4;
        m_valid = rd_en;
        m_err   = rd_en && (ri >= 256);
        m_werr  = wr_en && (wi >= 256);
        if (rd_en) begin
            if (ri < 256) begin
                m_data = m_mem[ri];
`ifdef RAM_BYPASS_EN
                if (wr_en && wi == ri) m_data = merge(m_mem[ri], wr_data, wr_be);
`endif
            end else begin
                m_data = 32'h0;
            end
        end
        if (wr_en && wi < 256) m_mem[wi] = merge(m_mem[wi], wr_data, wr_be);
        @(posedge clk);
        #1;
        check({name, "_valid"}, {31'h0, rd_valid}, {31'h0, m_valid});
        check({name, "_data"}, rd_data, m_data);
        check({name, "_rderr"}, {31'h0, rd_err}, {31'h0, m_err});
        check({name, "_wrerr"}, {31'h0, wr_err}, {31'h0, m_werr});
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] collide_exp;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_data = 32'h0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_valid", {31'h0, rd_valid}, 32'h0);
        check("reset_data", rd_data, 32'h0);
        check("reset_rderr", {31'h0, rd_err}, 32'h0);
        check("reset_wrerr", {31'h0, wr_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef RAM_BYPASS_EN
        collide_exp = 32'h11BB33DD;
`else
        collide_exp = 32'h11223344;
`endif
        //   re  rd_addr      we  be     wr_addr      wr_data       ev  e_data        ee  ew
        add(1, 32'h10,  0, 4'h0, 32'h0,   32'h0,        1, 32'h0,        0, 0);
        add(0, 32'h0,   1, 4'hF, 32'h20,  32'hDEADBEEF, 0, 32'h0,        0, 0);
        add(0, 32'h0,   1, 4'h1, 32'h20,  32'h000000AA, 0, 32'h0,        0, 0);
        add(1, 32'h23,  0, 4'h0, 32'h0,   32'h0,        1, 32'hDEADBEAA, 0, 0);
        add(0, 32'h0,   1, 4'hF, 32'h40,  32'h11223344, 0, 32'hDEADBEAA, 0, 0);
        add(1, 32'h40,  1, 4'h5, 32'h40,  32'hAABBCCDD, 1, collide_exp,  0, 0);
        add(1, 32'h40,  0, 4'h0, 32'h0,   32'h0,        1, 32'h11BB33DD, 0, 0);
        add(0, 32'h0,   1, 4'hF, 32'h400, 32'h12345678, 0, 32'h11BB33DD, 0, 1);
        add(1, 32'h400, 0, 4'h0, 32'h0,   32'h0,        1, 32'h0,        1, 0);
        add(1, 32'h0,   0, 4'h0, 32'h0,   32'h0,        1, 32'h0,        0, 0);
        add(0, 32'h0,   1, 4'hF, 32'h0,   32'h1,        0, 32'h0,        0, 0);
        add(0, 32'h0,   1, 4'hF, 32'h4,   32'h2,        0, 32'h0,        0, 0);
        add(1, 32'h0,   1, 4'hF, 32'h8,   32'h3,        1, 32'h1,        0, 0);
        add(1, 32'h4,   0, 4'h0, 32'h0,   32'h0,        1, 32'h2,        0, 0);
        add(1, 32'h8,   0, 4'h0, 32'h0,   32'h0,        1, 32'h3,        0, 0);
        add(1, 32'h4,   1, 4'h0, 32'h4,   32'hFFFFFFFF, 1, 32'h2,        0, 0);
        add(1, 32'h4,   0, 4'h0, 32'h0,   32'h0,        1, 32'h2,        0, 0);

        foreach (vecs[i]) begin
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            wr_en = vecs[i].wr_en; wr_be = vecs[i].wr_be;
            wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            tick($sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_valid", i), {31'h0, rd_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].e_data);
            check($sformatf("vec%0d_rderr", i), {31'h0, rd_err}, {31'h0, vecs[i].e_err});
            check($sformatf("vec%0d_wrerr", i), {31'h0, wr_err}, {31'h0, vecs[i].e_werr});
        end

        // Reset mid-read with a write pending: outputs clear at once, memory kept
        idle_inputs();
        rd_en = 1'b1; rd_addr = 32'h0;
        tick("prerst");
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 32'h8; wr_data = 32'h55;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", {31'h0, rd_valid}, 32'h0);
        check("rstmid_data", rd_data, 32'h0);
        check("rstmid_rderr", {31'h0, rd_err}, 32'h0);
        check("rstmid_wrerr", {31'h0, wr_err}, 32'h0);
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b1;
        m_data = 32'h0;
        tick("postrst_idle");
        rd_en = 1'b1; rd_addr = 32'h8;
        tick("postrst_rd8");
        check("postrst_word8", rd_data, 32'h3);

        // Randomized traffic, biased toward collisions and the range boundary
        for (int n = 0; n < 400; n++) begin
            rd_en   = 1'($urandom_range(0, 3) != 0);
            rd_addr = ($urandom_range(0, 271) << 2) | $urandom_range(0, 3);
            wr_en   = 1'($urandom_range(0, 1));
            wr_be   = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) wr_addr = (rd_addr & ~32'h3) | $urandom_range(0, 3);
            else wr_addr = ($urandom_range(0, 271) << 2) | $urandom_range(0, 3);
            if ((wr_addr >> 2) >= 256 && wr_be == 4'h0) wr_be = 4'h1;
            tick($sformatf("rand%0d", n));
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
